// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps at most one variable-latency instruction-memory
// request outstanding, and hands each instruction to decode over valid/ready.
module instr_fetch #(
    parameter int              PC_W     = 5,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    pc_plus1,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               imem_req_q, imem_req_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic [PC_W-1:0]    pc_plus1_q, pc_plus1_d;

    logic               redirect;
    logic [PC_W-1:0]    redirect_tgt;
    logic               issue;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
        return p + PC_W'(1);
    endfunction

    // The branch belongs to the older instruction, so it beats a jump.
    assign redirect     = branch_taken | jump;
    assign redirect_tgt = branch_taken ? branch_target : jump_target;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        imem_req_d    = 1'b0;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_pc_d    = instr_pc_q;
        pc_plus1_d    = pc_plus1_q;
        issue         = 1'b0;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d = redirect_tgt;
                end
                if (imem_req_q) begin
                    // Request is on the bus this cycle; a redirect makes its reply stale.
                    state_d = WAIT;
                    if (redirect) begin
                        kill_d = 1'b1;
                    end
                end else begin
                    // Only right after reset: nothing launched yet, so launch now.
                    issue = 1'b1;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        if (redirect) begin
                            pc_d = redirect_tgt;
                        end
                        state_d = FETCH;
                        issue   = 1'b1;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        pc_plus1_d    = pc_inc(pc_q);
                        pc_d          = pc_inc(pc_q);
                        instr_valid_d = 1'b1;
                        state_d       = OUT;
                    end
                end else if (redirect) begin
                    pc_d   = redirect_tgt;
                    kill_d = 1'b1;
                end
            end

            OUT: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_tgt;
                    state_d       = FETCH;
                    issue         = 1'b1;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                    issue         = 1'b1;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // Launching one edge early keeps the request in the FETCH cycle itself.
        if (issue) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
            pc_plus1_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
            pc_plus1_q    <= pc_plus1_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus1    = pc_plus1_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: variable-latency memory model, request/handshake
// scoreboards, a table of sequential runs and hand-written redirect/reset cases.
module tb_instr_fetch;

    localparam int         PC_W     = 5;
    localparam int         INSTR_W  = 8;
    localparam logic [4:0] RESET_PC = 5'd0;
    localparam int         NV       = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               imem_rvalid = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic [PC_W-1:0]    instr_pc;
    logic [PC_W-1:0]    pc_plus1;
    logic               branch_taken = 1'b0;
    logic [PC_W-1:0]    branch_target = '0;
    logic               jump = 1'b0;
    logic [PC_W-1:0]    jump_target = '0;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_pc(instr_pc), .pc_plus1(pc_plus1),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] pc;
        logic [7:0] ins;
        logic [4:0] pc1;
    } hs_t;

    typedef struct {
        logic [4:0]      start;
        int              lat;
        int              stall;
        int              n;
        int              gap;
        logic [3:0][4:0] pcs;
    } vec_t;

    logic [7:0] mem [32];
    logic [4:0] exp_req [$];
    hs_t        exp_hs [$];
    vec_t       vecs [NV];

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int cyc = 0;
    int lat_cfg = 1;
    int exp_gap = 0;
    bit first_in_run = 1'b0;
    int last_hs_cyc = 0;

    bit         pend = 1'b0;
    int         cnt = 0;
    logic [4:0] paddr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor first, then the memory model, so the outstanding flag is pre-update.
    always @(negedge clk) begin
        if (reset) begin
            pend        = 1'b0;
            cnt         = 0;
            imem_rvalid = 1'b0;
        end else begin
            if (imem_req) begin
                chk("one_outstanding", {31'd0, pend}, 32'd0);
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", {27'd0, imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    chk("req_addr", {27'd0, imem_addr}, {27'd0, exp_req.pop_front()});
                end
            end
            if (instr_valid && instr_ready) begin
                hs_t h;
                hs_cnt++;
                if (exp_hs.size() == 0) begin
                    chk("hs_unexpected", {27'd0, instr_pc}, 32'hFFFF_FFFF);
                end else begin
                    h = exp_hs.pop_front();
                    chk("hs_instr", {24'd0, instr}, {24'd0, h.ins});
                    chk("hs_pc", {27'd0, instr_pc}, {27'd0, h.pc});
                    chk("hs_pc_plus1", {27'd0, pc_plus1}, {27'd0, h.pc1});
                end
                if (exp_gap != 0 && !first_in_run) begin
                    chk("hs_gap", cyc - last_hs_cyc, exp_gap);
                end
                last_hs_cyc  = cyc;
                first_in_run = 1'b0;
            end
            imem_rvalid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[paddr];
                    pend        = 1'b0;
                end
            end
            if (imem_req) begin
                pend  = 1'b1;
                cnt   = lat_cfg;
                paddr = imem_addr;
            end
        end
    end

    task automatic start_seq(input logic [4:0] tgt, input int lat, input bit prime);
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        lat_cfg      = lat;
        reset        = 1'b1;
        @(posedge clk); #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", {27'd0, imem_addr}, {27'd0, RESET_PC});
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", {24'd0, instr}, 32'd0);
        chk("rst_instr_pc", {27'd0, instr_pc}, 32'd0);
        chk("rst_pc_plus1", {27'd0, pc_plus1}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        if (prime) begin
            jump        = 1'b1;
            jump_target = tgt;
            @(posedge clk); #1;
            jump = 1'b0;
        end
    endtask

    task automatic run_hs(input int n, input int stall, input int gap);
        int base  = hs_cnt;
        int guard = 0;
        int st    = stall;
        exp_gap      = gap;
        first_in_run = 1'b1;
        while ((hs_cnt - base) < n && guard < 300) begin
            if (instr_valid && st > 0) begin
                instr_ready = 1'b0;
                if (exp_hs.size() > 0) begin
                    chk("stall_instr", {24'd0, instr}, {24'd0, exp_hs[0].ins});
                    chk("stall_pc", {27'd0, instr_pc}, {27'd0, exp_hs[0].pc});
                    chk("stall_pc_plus1", {27'd0, pc_plus1}, {27'd0, exp_hs[0].pc1});
                end
                chk("stall_no_req", {31'd0, imem_req}, 32'd0);
                st--;
            end else begin
                instr_ready = 1'b1;
            end
            @(posedge clk); #1;
            guard++;
        end
        instr_ready = 1'b0;
        exp_gap     = 0;
        if (guard >= 300) chk("hs_timeout", hs_cnt - base, n);
    endtask

    task automatic wait_valid(input string nm);
        int g = 0;
        while (!instr_valid && g < 30) begin
            @(posedge clk); #1;
            g++;
        end
        chk(nm, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic finish_seq();
        repeat (4) @(posedge clk);
        #1;
        chk("req_queue_left", exp_req.size(), 0);
        chk("hs_queue_left", exp_hs.size(), 0);
        exp_req.delete();
        exp_hs.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'h2A + 8'(i * 37);

        vecs[0] = '{5'h02, 3, 4, 1, 5, {5'h00, 5'h00, 5'h03, 5'h02}};
        vecs[1] = '{5'h1E, 1, 0, 3, 3, {5'h01, 5'h00, 5'h1F, 5'h1E}};
        vecs[2] = '{5'h0A, 2, 1, 3, 4, {5'h0D, 5'h0C, 5'h0B, 5'h0A}};
        vecs[3] = '{5'h1F, 5, 2, 2, 7, {5'h00, 5'h01, 5'h00, 5'h1F}};

        // First fetch after reset, one-cycle memory.
        exp_req.push_back(5'h00);
        exp_req.push_back(5'h01);
        exp_hs.push_back('{5'h00, 8'h2A, 5'h01});
        start_seq(5'h00, 1, 1'b0);
        g = 0;
        while (!imem_req && g < 10) begin
            @(posedge clk); #1;
            g++;
        end
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", {27'd0, imem_addr}, 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_early", {31'd0, instr_valid}, 32'd0);
        @(posedge clk); #1;
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", {24'd0, instr}, 32'h2A);
        chk("t1_instr_pc", {27'd0, instr_pc}, 32'd0);
        chk("t1_pc_plus1", {27'd0, pc_plus1}, 32'd1);
        run_hs(1, 0, 0);
        finish_seq();

        // Table of sequential runs.
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i <= vecs[v].n; i++) exp_req.push_back(vecs[v].pcs[i]);
            for (int i = 0; i < vecs[v].n; i++)
                exp_hs.push_back('{vecs[v].pcs[i], mem[vecs[v].pcs[i]], vecs[v].pcs[i+1]});
            start_seq(vecs[v].start, vecs[v].lat, 1'b1);
            run_hs(vecs[v].n, vecs[v].stall, vecs[v].gap);
            finish_seq();
        end

        // Jump while waiting on address 5.
        exp_req.push_back(5'h05);
        exp_req.push_back(5'h10);
        exp_req.push_back(5'h11);
        exp_hs.push_back('{5'h10, mem[5'h10], 5'h11});
        start_seq(5'h05, 3, 1'b1);
        @(posedge clk); #1;
        jump = 1'b1; jump_target = 5'h10;
        @(posedge clk); #1;
        jump = 1'b0;
        run_hs(1, 0, 0);
        finish_seq();

        // Jump in the same cycle the request goes out.
        exp_req.push_back(5'h07);
        exp_req.push_back(5'h14);
        exp_req.push_back(5'h15);
        exp_hs.push_back('{5'h14, mem[5'h14], 5'h15});
        start_seq(5'h07, 2, 1'b1);
        jump = 1'b1; jump_target = 5'h14;
        @(posedge clk); #1;
        jump = 1'b0;
        run_hs(1, 0, 0);
        finish_seq();

        // Branch and jump together while an instruction is held.
        exp_req.push_back(5'h08);
        exp_req.push_back(5'h04);
        exp_req.push_back(5'h05);
        exp_hs.push_back('{5'h04, mem[5'h04], 5'h05});
        start_seq(5'h08, 1, 1'b1);
        wait_valid("bj_valid_held");
        branch_taken = 1'b1; branch_target = 5'h04;
        jump = 1'b1; jump_target = 5'h1F;
        @(posedge clk); #1;
        branch_taken = 1'b0; jump = 1'b0;
        chk("bj_squash", {31'd0, instr_valid}, 32'd0);
        chk("bj_req", {31'd0, imem_req}, 32'd1);
        chk("bj_addr", {27'd0, imem_addr}, 32'h04);
        run_hs(1, 0, 0);
        finish_seq();

        // Asynchronous reset in the middle of a wait.
        exp_req.push_back(5'h03);
        start_seq(5'h03, 4, 1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rw_valid", {31'd0, instr_valid}, 32'd0);
        chk("rw_req", {31'd0, imem_req}, 32'd0);
        exp_req.push_back(RESET_PC);
        exp_req.push_back(5'h01);
        exp_hs.push_back('{RESET_PC, mem[RESET_PC], 5'h01});
        start_seq(5'h00, 1, 1'b0);
        run_hs(1, 0, 0);
        finish_seq();

        // Asynchronous reset while an instruction is presented.
        exp_req.push_back(5'h09);
        start_seq(5'h09, 1, 1'b1);
        wait_valid("ro_valid_held");
        #3;
        reset = 1'b1;
        #1;
        chk("ro_valid", {31'd0, instr_valid}, 32'd0);
        chk("ro_instr", {24'd0, instr}, 32'd0);
        finish_seq();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
